// File: rtl/muldiv_pkg.sv
//------------------------------------------------------------------------------
// Module : muldiv_pkg
// Brief  : Shared types and constants for the multiply/divide sequencer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MRUN = 2'b01,
    S_DRUN = 2'b10,
    S_CAPT = 2'b11
  } state_e;

  localparam int MULT_CYCLES_DFLT = 33;
  localparam int DIV_CYCLES_DFLT  = 33;
  localparam int TIMER_W          = 6;

endpackage

`default_nettype wire

// File: rtl/muldiv_if.sv
//------------------------------------------------------------------------------
// Module : muldiv_if
// Brief  : Operation/read handshake between the control unit and muldiv_ctrl.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface muldiv_if;
  import muldiv_pkg::*;

  logic        op_valid;
  op_e         op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_ready;
  logic        op_done;
  logic        exc_div0;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        stall;

  modport master (
    output op_valid, op_code, op_a, op_b, rd_req, rd_sel,
    input  op_ready, op_done, exc_div0, rd_data, stall
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, rd_req, rd_sel,
    output op_ready, op_done, exc_div0, rd_data, stall
  );

endinterface

`default_nettype wire

// File: rtl/muldiv_timer.sv
//------------------------------------------------------------------------------
// Module : muldiv_timer
// Brief  : Loadable down-counter with zero flag, shared by both run states.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] r_cnt;

  // Saturates at zero so a stray decrement can never wrap into a long run.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
//------------------------------------------------------------------------------
// Module : muldiv_ctrl
// Brief  : Sequences the multi-cycle multiplier/divider and owns HI/LO.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DFLT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_if.slave     bus,
  output logic        mult_start,
  input  logic        mult_end,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        div_start,
  input  logic        div_end,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        seq_err,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_unit_div;
  logic                r_end_seen;
  logic                r_seq_err;
  logic                r_mult_start;
  logic                r_div_start;
  logic                r_op_done;
  logic                r_exc_div0;
  logic                r_op_ready;
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;

  logic                w_accept;
  logic                w_tmr_load;
  logic [TIMER_W-1:0]  w_tmr_val;
  logic                w_tmr_dec;
  logic                w_tmr_zero;
  logic                w_unit_nxt;
  logic                w_seen_nxt;
  logic                w_err_nxt;
  logic                w_mstart_nxt;
  logic                w_dstart_nxt;
  logic                w_done_nxt;
  logic                w_div0_nxt;
  logic [31:0]         w_hi_nxt;
  logic [31:0]         w_lo_nxt;

  muldiv_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .dec      (w_tmr_dec),
    .zero     (w_tmr_zero)
  );

  assign w_accept = bus.op_valid && (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    w_tmr_dec    = 1'b0;
    w_unit_nxt   = r_unit_div;
    w_seen_nxt   = r_end_seen;
    w_err_nxt    = r_seq_err;
    w_mstart_nxt = r_mult_start;
    w_dstart_nxt = r_div_start;
    w_done_nxt   = 1'b0;
    w_div0_nxt   = 1'b0;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.op_code)
            OP_MULT: begin
              w_state_nxt  = S_MRUN;
              w_tmr_load   = 1'b1;
              w_tmr_val    = TIMER_W'(MULT_CYCLES - 1);
              w_mstart_nxt = 1'b1;
              w_unit_nxt   = 1'b0;
              w_seen_nxt   = 1'b0;
            end
            OP_DIV: begin
              // Divide by zero is trapped here; the divider is never started.
              if (bus.op_b == 32'd0) begin
                w_div0_nxt = 1'b1;
              end else begin
                w_state_nxt  = S_DRUN;
                w_tmr_load   = 1'b1;
                w_tmr_val    = TIMER_W'(DIV_CYCLES - 1);
                w_dstart_nxt = 1'b1;
                w_unit_nxt   = 1'b1;
                w_seen_nxt   = 1'b0;
              end
            end
            OP_MTHI: begin
              w_hi_nxt   = bus.op_a;
              w_done_nxt = 1'b1;
            end
            OP_MTLO: begin
              w_lo_nxt   = bus.op_a;
              w_done_nxt = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MRUN: begin
        w_seen_nxt = r_end_seen | mult_end;
        if (w_tmr_zero) begin
          w_mstart_nxt = 1'b0;
          w_state_nxt  = S_CAPT;
          if (!(r_end_seen | mult_end)) w_err_nxt = 1'b1;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      S_DRUN: begin
        w_seen_nxt = r_end_seen | div_end;
        if (w_tmr_zero) begin
          w_dstart_nxt = 1'b0;
          w_state_nxt  = S_CAPT;
          if (!(r_end_seen | div_end)) w_err_nxt = 1'b1;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      S_CAPT: begin
        w_hi_nxt    = r_unit_div ? div_hi : mult_hi;
        w_lo_nxt    = r_unit_div ? div_lo : mult_lo;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_unit_div   <= 1'b0;
      r_end_seen   <= 1'b0;
      r_seq_err    <= 1'b0;
      r_mult_start <= 1'b0;
      r_div_start  <= 1'b0;
      r_op_done    <= 1'b0;
      r_exc_div0   <= 1'b0;
      r_op_ready   <= 1'b0;
      r_hi         <= '0;
      r_lo         <= '0;
    end else begin
      r_unit_div   <= w_unit_nxt;
      r_end_seen   <= w_seen_nxt;
      r_seq_err    <= w_err_nxt;
      r_mult_start <= w_mstart_nxt;
      r_div_start  <= w_dstart_nxt;
      r_op_done    <= w_done_nxt;
      r_exc_div0   <= w_div0_nxt;
      r_op_ready   <= (w_state_nxt == S_IDLE);
      r_hi         <= w_hi_nxt;
      r_lo         <= w_lo_nxt;
    end
  end

  // Start levels are masked by reset so an abort stops the units in that same cycle.
  assign mult_start   = r_mult_start & rst;
  assign div_start    = r_div_start & rst;
  assign seq_err      = r_seq_err;
  assign hi           = r_hi;
  assign lo           = r_lo;

  assign bus.op_ready = r_op_ready;
  assign bus.op_done  = r_op_done;
  assign bus.exc_div0 = r_exc_div0;
  assign bus.rd_data  = bus.rd_sel ? r_lo : r_hi;
  assign bus.stall    = (bus.op_valid | bus.rd_req) & ~r_op_ready;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_muldiv_ctrl
// Brief  : Directed scoreboard bench for muldiv_ctrl with behavioural unit stubs.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mult_start, mult_end, div_start, div_end, seq_err;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo, hi, lo;

  muldiv_if bus ();

  muldiv_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .mult_start (mult_start),
    .mult_end   (mult_end),
    .mult_hi    (mult_hi),
    .mult_lo    (mult_lo),
    .div_start  (div_start),
    .div_end    (div_end),
    .div_hi     (div_hi),
    .div_lo     (div_lo),
    .seq_err    (seq_err),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] sbq[$];

  // Unit stubs: latch operands on accept, raise end flag in the last run cycle.
  logic [31:0]        sa = '0;
  logic [31:0]        sbv = '0;
  logic               mend_en = 1'b1;
  int                 mcnt = 0;
  int                 dcnt = 0;
  logic signed [63:0] prod;

  always @(posedge clk) begin
    if (bus.op_valid && bus.op_ready) begin
      sa  <= bus.op_a;
      sbv <= bus.op_b;
    end
    mcnt <= mult_start ? mcnt + 1 : 0;
    dcnt <= div_start ? dcnt + 1 : 0;
  end

  assign prod     = longint'($signed(sa)) * longint'($signed(sbv));
  assign mult_hi  = prod[63:32];
  assign mult_lo  = prod[31:0];
  assign mult_end = mend_en & mult_start & (mcnt == MULT_CYCLES_DFLT - 1);
  assign div_end  = div_start & (dcnt == DIV_CYCLES_DFLT - 1);

  always_comb begin
    div_hi = '0;
    div_lo = '0;
    if (sbv != 32'd0) begin
      div_lo = $signed(sa) / $signed(sbv);
      div_hi = $signed(sa) % $signed(sbv);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input op_e code, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_hilo, input logic chk_stall);
    int          lat;
    int          starts;
    int          stall_bad;
    logic [63:0] e;
    lat       = -1;
    starts    = 0;
    stall_bad = 0;
    sbq.push_back(exp_hilo);
    @(negedge clk);
    chk("ready_before", 64'(bus.op_ready), 64'd1);
    bus.op_code  = code;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_valid = 1'b1;
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      @(negedge clk);
      if (mult_start | div_start) starts++;
      if (bus.op_done) lat = k - 1;
      else if (chk_stall && bus.stall !== 1'b1) stall_bad++;
    end
    chk("done_latency", 64'(lat), 64'd34);
    chk("start_cycles", 64'(starts), 64'd33);
    e = sbq.pop_front();
    chk("hilo", {hi, lo}, e);
    chk("ready_after", 64'(bus.op_ready), 64'd1);
    if (chk_stall) begin
      chk("stall_busy", 64'(stall_bad), 64'd0);
      chk("stall_idle", 64'(bus.stall), 64'd0);
      chk("rd_data_lo", 64'(bus.rd_data), 64'(e[31:0]));
    end
    @(negedge clk);
    chk("done_pulse_end", 64'(bus.op_done), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    bus.op_valid = 1'b0;
    bus.op_code  = OP_MULT;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.rd_req   = 1'b0;
    bus.rd_sel   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_done", 64'(bus.op_done), 64'd0);
    chk("rst_ready", 64'(bus.op_ready), 64'd0);
    chk("rst_mstart", 64'(mult_start), 64'd0);
    chk("rst_dstart", 64'(div_start), 64'd0);
    chk("rst_seqerr", 64'(seq_err), 64'd0);
    chk("rst_div0", 64'(bus.exc_div0), 64'd0);
    rst = 1'b1;

    // MULT 7 * -3
    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    chk("mult_seqerr", 64'(seq_err), 64'd0);

    // DIV 100 / 7
    run_op(OP_DIV, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    chk("div_seqerr", 64'(seq_err), 64'd0);

    // DIV by zero
    @(negedge clk);
    bus.op_code  = OP_DIV;
    bus.op_a     = 32'd55;
    bus.op_b     = 32'd0;
    bus.op_valid = 1'b1;
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    @(negedge clk);
    chk("div0_pulse", 64'(bus.exc_div0), 64'd1);
    chk("div0_nostart", 64'(div_start), 64'd0);
    chk("div0_ready", 64'(bus.op_ready), 64'd1);
    chk("div0_nodone", 64'(bus.op_done), 64'd0);
    chk("div0_hilo", {hi, lo}, {32'd2, 32'd14});
    @(negedge clk);
    chk("div0_pulse_end", 64'(bus.exc_div0), 64'd0);
    chk("div0_nostart2", 64'(div_start), 64'd0);

    // MTHI with a same-cycle HI read, then MTLO back-to-back
    bus.op_code  = OP_MTHI;
    bus.op_a     = 32'hDEAD_BEEF;
    bus.op_valid = 1'b1;
    bus.rd_req   = 1'b1;
    bus.rd_sel   = 1'b0;
    #1;
    chk("mthi_old_hi", 64'(bus.rd_data), 64'd2);
    chk("mthi_nostall", 64'(bus.stall), 64'd0);
    @(posedge clk);
    #1;
    bus.rd_req  = 1'b0;
    bus.op_code = OP_MTLO;
    bus.op_a    = 32'hCAFE_F00D;
    @(negedge clk);
    chk("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
    chk("mthi_done", 64'(bus.op_done), 64'd1);
    chk("mthi_ready", 64'(bus.op_ready), 64'd1);
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    @(negedge clk);
    chk("mtlo_lo", 64'(lo), 64'hCAFE_F00D);
    chk("mtlo_hi_kept", 64'(hi), 64'hDEAD_BEEF);
    chk("mtlo_done", 64'(bus.op_done), 64'd1);

    // MULT in flight with a pending LO read
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b1;
    run_op(OP_MULT, 32'h0001_2345, 32'h0010_0003, 64'h0000_0012_3453_69CF, 1'b1);
    bus.rd_req = 1'b0;

    // Reset at cycle 10 of a MULT
    @(negedge clk);
    bus.op_code  = OP_MULT;
    bus.op_a     = 32'd9;
    bus.op_b     = 32'd9;
    bus.op_valid = 1'b1;
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_mstart_now", 64'(mult_start), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_mstart", 64'(mult_start), 64'd0);
    chk("abort_done", 64'(bus.op_done), 64'd0);
    rst = 1'b1;
    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    chk("post_abort_seqerr", 64'(seq_err), 64'd0);

    // Multiplier never raises its end flag
    mend_en = 1'b0;
    run_op(OP_MULT, 32'd5, 32'd6, 64'd30, 1'b0);
    chk("noend_seqerr", 64'(seq_err), 64'd1);
    mend_en = 1'b1;
    run_op(OP_DIV, 32'd9, 32'd2, {32'd1, 32'd4}, 1'b0);
    chk("seqerr_sticky", 64'(seq_err), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("seqerr_cleared", 64'(seq_err), 64'd0);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
